mul_share_sched: RTL and testbench

//  Round-robin scheduler sharing one iterative shift-and-add multiplier (MUL) among NUM_REQ requesters.

---
 rtl/mul_share_sched.sv | 150 +++++++++++++++
 tb/tb_mul_share_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// Round-robin scheduler that shares one iterative multiplier among NUM_REQ requesters.
// Optionally pads every response to a fixed latency so operand-dependent early finish is not visible.
module mul_share_sched #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 4,
  parameter int CONST_TIME = 1,
  parameter int LAT        = 7,
  parameter int TIMEOUT    = 16,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int OUT_WIDTH = 2 * WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [ID_W-1:0]            resp_id,
  output logic [OUT_WIDTH-1:0]       resp_o,
  output logic                       resp_err,
  output logic                       mul_in_valid,
  output logic                       mul_stall,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [OUT_WIDTH-1:0]       mul_o,
  input  logic                       mul_out_valid,
  output logic [1:0]                 dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
  // valid never waits on ready, and the response payload holds steady until it is taken.

  localparam int CNT_W = $clog2(TIMEOUT + LAT + 1);
  localparam logic [CNT_W-1:0] REL_CNT = CNT_W'(LAT - 2);
  localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_RESP = 2'd3} state_t;

  state_t               state;
  logic [ID_W-1:0]      rr_ptr, id_q;
  logic [CNT_W-1:0]     cnt;
  logic                 done, err;
  logic [OUT_WIDTH-1:0] res;
  logic [WIDTH-1:0]     a_q, b_q;

  logic                 lo_found, hi_found, grant_ok, capture, rel_ok;
  logic [ID_W-1:0]      lo_id, hi_id, gnt_id;
  logic [WIDTH-1:0]     sel_a, sel_b;

  // Prefer the lowest valid index at or above rr_ptr, otherwise wrap to the lowest valid index.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_id    = '0;
    hi_id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = ID_W'(i);
      end
      if (req_valid[i] && (ID_W'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_id    = ID_W'(i);
      end
    end
    gnt_id = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == gnt_id) begin
        sel_a = req_a[i*WIDTH +: WIDTH];
        sel_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign grant_ok  = (state == S_IDLE) && !freeze && lo_found;
  assign req_ready = grant_ok ? (NUM_REQ'(1) << gnt_id) : '0;
  // A finish seen at cnt==0 belongs to an earlier, aborted operation.
  assign capture   = (state == S_WAIT) && mul_out_valid && (cnt != '0) && !done;
  assign rel_ok    = (CONST_TIME == 0) || (cnt >= REL_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      rr_ptr <= '0;
      id_q   <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      res    <= '0;
      a_q    <= '0;
      b_q    <= '0;
    end else if (!freeze) begin
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            a_q    <= sel_a;
            b_q    <= sel_b;
            id_q   <= gnt_id;
            rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          if (capture) begin
            res  <= mul_o;
            done <= 1'b1;
            if (rel_ok) state <= S_RESP;
          end else if (done && rel_ok) begin
            state <= S_RESP;
          end else if (!done && (cnt == TO_CNT)) begin
            res   <= '0;
            err   <= 1'b1;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            done  <= 1'b0;
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid   = (state == S_RESP) && !freeze;
  assign resp_id      = id_q;
  assign resp_o       = res;
  assign resp_err     = err;
  assign mul_in_valid = (state == S_ISSUE);
  assign mul_stall    = freeze;
  assign mul_a        = a_q;
  assign mul_b        = b_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_mul_share_sched.sv
// Directed bench for mul_share_sched: a constant-time instance (index 0) and an early-release
// instance (index 1), each driving its own behavioural shift-and-add multiplier model.
module tb_mul_share_sched;
  localparam int NR = 4;
  localparam int W  = 4;
  localparam int OW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic            frz          [2];
  logic [NR-1:0]   req_valid    [2];
  logic [NR*W-1:0] req_a        [2];
  logic [NR*W-1:0] req_b        [2];
  logic [NR-1:0]   req_ready    [2];
  logic            resp_valid   [2];
  logic            resp_ready   [2];
  logic [1:0]      resp_id      [2];
  logic [OW-1:0]   resp_o       [2];
  logic            resp_err     [2];
  logic            mul_in_valid [2];
  logic            mul_stall    [2];
  logic [W-1:0]    mul_a        [2];
  logic [W-1:0]    mul_b        [2];
  logic [OW-1:0]   mul_o        [2];
  logic            mul_out_valid[2];
  logic [1:0]      dbg_state    [2];
  logic            mute         [2];
  logic            stray        [2];

  int passed = 0;
  int total  = 0;

  mul_share_sched #(.CONST_TIME(1)) u_ct (
    .clk(clk), .rst(rst), .freeze(frz[0]),
    .req_valid(req_valid[0]), .req_a(req_a[0]), .req_b(req_b[0]), .req_ready(req_ready[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_id(resp_id[0]),
    .resp_o(resp_o[0]), .resp_err(resp_err[0]),
    .mul_in_valid(mul_in_valid[0]), .mul_stall(mul_stall[0]), .mul_a(mul_a[0]), .mul_b(mul_b[0]),
    .mul_o(mul_o[0]), .mul_out_valid(mul_out_valid[0]), .dbg_state(dbg_state[0])
  );

  mul_share_sched #(.CONST_TIME(0)) u_nc (
    .clk(clk), .rst(rst), .freeze(frz[1]),
    .req_valid(req_valid[1]), .req_a(req_a[1]), .req_b(req_b[1]), .req_ready(req_ready[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_id(resp_id[1]),
    .resp_o(resp_o[1]), .resp_err(resp_err[1]),
    .mul_in_valid(mul_in_valid[1]), .mul_stall(mul_stall[1]), .mul_a(mul_a[1]), .mul_b(mul_b[1]),
    .mul_o(mul_o[1]), .mul_out_valid(mul_out_valid[1]), .dbg_state(dbg_state[1])
  );

  function automatic int bitlen(input logic [W-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n;
  endfunction

  // Multiplier model: finishes 1 + bitlen(b) cycles after in_valid (1 cycle if a==0), pauses on stall.
  for (genvar d = 0; d < 2; d++) begin : g_mdl
    logic          busy = 1'b0;
    logic          ov   = 1'b0;
    int            left = 0;
    logic [OW-1:0] prod = '0;
    always @(posedge clk) begin
      if (!mul_stall[d]) begin
        ov <= 1'b0;
        if (mul_in_valid[d]) begin
          busy <= 1'b1;
          left <= 1 + ((mul_a[d] == '0) ? 0 : bitlen(mul_b[d]));
          prod <= {4'd0, mul_a[d]} * {4'd0, mul_b[d]};
        end else if (busy) begin
          left <= left - 1;
          if (left == 1) begin
            busy <= 1'b0;
            ov   <= !mute[d];
          end
        end
      end
    end
    assign mul_out_valid[d] = ov | stray[d];
    assign mul_o[d]         = prod;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] outs(input int d);
    return {6'd0, req_ready[d], resp_valid[d], resp_id[d], resp_o[d], resp_err[d],
            mul_in_valid[d], mul_stall[d], mul_a[d], mul_b[d]};
  endfunction

  // One full operation: request, grant, issue, wait (optional freeze), response (optional hold), handshake.
  task automatic do_op(input int d, input logic [NR-1:0] vmask, input int g,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic [OW-1:0] exp_o,
                       input int exp_lat, input logic exp_err, input int hold, input int frz_at,
                       output int lat);
    int wc;
    req_a[d][g*W +: W] = a;
    req_b[d][g*W +: W] = b;
    req_valid[d] = vmask;
    #1;
    wc = 0;
    while (req_ready[d] == '0 && wc < 20) begin
      @(negedge clk); #1; wc++;
    end
    chk("grant", {28'd0, req_ready[d]}, 32'(1 << g));
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = '0;
    #1;
    chk("issue", {23'd0, mul_in_valid[d], mul_a[d], mul_b[d]}, {23'd0, 1'b1, a, b});
    lat = 0;
    while (!resp_valid[d] && lat < 40) begin
      @(negedge clk);
      lat++;
      frz[d] = (frz_at >= 0) && (lat >= frz_at) && (lat < frz_at + 3);
      #1;
      if (lat == frz_at) chk("stall", {31'd0, mul_stall[d]}, 32'd1);
    end
    if (exp_lat >= 0) chk("latency", lat, exp_lat);
    chk("resp_id", {30'd0, resp_id[d]}, 32'(g));
    chk("resp_o", {24'd0, resp_o[d]}, {24'd0, exp_o});
    chk("resp_err", {31'd0, resp_err[d]}, {31'd0, exp_err});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold", {20'd0, resp_valid[d], resp_id[d], resp_o[d], resp_err[d]},
          {20'd0, 1'b1, 2'(g), exp_o, exp_err});
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
    #1;
    chk("released", {31'd0, resp_valid[d]}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat_big, lat_small;
    logic seen;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      frz[d] = 1'b0; req_valid[d] = '0; req_a[d] = '0; req_b[d] = '0;
      resp_ready[d] = 1'b0; mute[d] = 1'b0; stray[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_outputs", outs(0), 32'd0);
    chk("rst_state", {30'd0, dbg_state[0]}, 32'd0);
    rst = 1'b0;

    // Reset in the middle of WAIT, then a late finish from the aborted op plus an injected pulse
    @(negedge clk);
    req_a[0][3:0] = 4'd3; req_b[0][3:0] = 4'd5; req_valid[0] = 4'b0001;
    @(negedge clk);
    req_valid[0] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", outs(0), 32'd0);
    chk("rst_mid_state", {30'd0, dbg_state[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    stray[0] = 1'b1;
    @(negedge clk);
    stray[0] = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk); #1;
      if (resp_valid[0]) seen = 1'b1;
    end
    chk("no_stray_resp", {31'd0, seen}, 32'd0);
    chk("idle_after_stray", {30'd0, dbg_state[0]}, 32'd0);

    // Constant-time: same 7-cycle latency for slow and early-finishing operands
    do_op(0, 4'b0001, 0, 4'd3, 4'd5, 8'd15, 7, 1'b0, 0, -1, lat);
    do_op(0, 4'b0001, 0, 4'd0, 4'd5, 8'd0,  7, 1'b0, 0, -1, lat);

    // Early release: latency follows the multiplier
    do_op(1, 4'b0001, 0, 4'd15, 4'd15, 8'd225, 7, 1'b0, 0, -1, lat_big);
    do_op(1, 4'b0001, 0, 4'd9,  4'd0,  8'd0,   3, 1'b0, 0, -1, lat_small);
    chk("early_is_faster", {31'd0, (lat_small < lat_big)}, 32'd1);

    // Backpressure 5 cycles plus a 3-cycle freeze in WAIT (pointer is 1, so req2 is granted)
    do_op(0, 4'b0100, 2, 4'd7, 4'd6, 8'd42, 10, 1'b0, 5, 2, lat);

    // Freeze in IDLE blocks grants and holds state
    frz[0] = 1'b1;
    req_valid[0] = 4'b1111;
    #1;
    chk("frz_no_ready", {28'd0, req_ready[0]}, 32'd0);
    chk("frz_stall", {31'd0, mul_stall[0]}, 32'd1);
    @(negedge clk); #1;
    chk("frz_state_held", {30'd0, dbg_state[0]}, 32'd0);
    frz[0] = 1'b0;
    req_valid[0] = '0;
    #1;
    chk("unfrz_stall", {31'd0, mul_stall[0]}, 32'd0);

    // Timeout: multiplier never finishes; the following op is normal
    mute[0] = 1'b1;
    do_op(0, 4'b1000, 3, 4'd5, 4'd5, 8'd0, 17, 1'b1, 0, -1, lat);
    mute[0] = 1'b0;
    do_op(0, 4'b0010, 1, 4'd2, 4'd3, 8'd6, 7, 1'b0, 0, -1, lat);

    // Round robin from a fresh pointer with all requesters valid
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(0, 4'b1111, 0, 4'd1, 4'd2, 8'd2,  7, 1'b0, 0, -1, lat);
    do_op(0, 4'b1111, 1, 4'd2, 4'd2, 8'd4,  7, 1'b0, 0, -1, lat);
    do_op(0, 4'b1111, 2, 4'd3, 4'd2, 8'd6,  7, 1'b0, 0, -1, lat);
    do_op(0, 4'b1111, 3, 4'd4, 4'd2, 8'd8,  7, 1'b0, 0, -1, lat);
    do_op(0, 4'b1111, 0, 4'd5, 4'd2, 8'd10, 7, 1'b0, 0, -1, lat);
    do_op(0, 4'b0010, 1, 4'd6, 4'd2, 8'd12, 7, 1'b0, 0, -1, lat);
    do_op(0, 4'b0010, 1, 4'd7, 4'd2, 8'd14, 7, 1'b0, 0, -1, lat);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
